// File: rtl/rtc_pkg.sv
// Shared widths, field limits, month-length rule and set-time FSM states
// for the real-time calendar.
package rtc_pkg;

  localparam int SEC_W   = 6;
  localparam int MIN_W   = 6;
  localparam int HOUR_W  = 5;
  localparam int DAY_W   = 5;
  localparam int MONTH_W = 4;
  localparam int YEAR_W  = 7;

  localparam logic [SEC_W-1:0]   MAX_SEC   = 6'd59;
  localparam logic [MIN_W-1:0]   MAX_MIN   = 6'd59;
  localparam logic [HOUR_W-1:0]  MAX_HOUR  = 5'd23;
  localparam logic [MONTH_W-1:0] MAX_MONTH = 4'd12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } set_state_e;

  // Year 0 is 2000, so every year divisible by four is a leap year.
  function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] month,
                                                     input logic [YEAR_W-1:0]  year);
    case (month)
      4'd2:                  days_in_month = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
      default:               days_in_month = 5'd31;
    endcase
  endfunction

endpackage

// File: rtl/rtc_tick_gen.sv
// Prescaler dividing clk down to a one-cycle strobe per second.
// tick is high in the cycle the counter sits at its terminal count while running.
module rtc_tick_gen
  import rtc_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int                CNT_W = $clog2(CLK_HZ);
  localparam logic [CNT_W-1:0]  TERM  = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = run && (cnt == TERM);

  // clear beats run so a fresh load always starts a full second.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      if (cnt == TERM) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rtc_calendar.sv
// Binary calendar clock: 1 Hz cascade from seconds to year plus a
// range-checked set-time load through a three-state handshake FSM.
module rtc_calendar
  import rtc_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int YEAR_MAX = 99
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               set_valid,
  output logic               set_ready,
  input  logic [SEC_W-1:0]   set_sec,
  input  logic [MIN_W-1:0]   set_min,
  input  logic [HOUR_W-1:0]  set_hour,
  input  logic [DAY_W-1:0]   set_day,
  input  logic [MONTH_W-1:0] set_month,
  input  logic [YEAR_W-1:0]  set_year,
  output logic               set_err,
  output logic [SEC_W-1:0]   second,
  output logic [MIN_W-1:0]   minute,
  output logic [HOUR_W-1:0]  hour,
  output logic [DAY_W-1:0]   day,
  output logic [MONTH_W-1:0] month,
  output logic [YEAR_W-1:0]  year,
  output logic               tick_1hz,
  output logic               day_roll,
  output set_state_e         set_state
);

  localparam logic [YEAR_W-1:0] YMAX = YEAR_W'(YEAR_MAX);

  set_state_e state_q, state_d;
  logic       err_q;
  logic       fields_ok;
  logic       load;
  logic       wrap;

  logic [SEC_W-1:0]   sec_n;
  logic [MIN_W-1:0]   min_n;
  logic [HOUR_W-1:0]  hour_n;
  logic [DAY_W-1:0]   day_n;
  logic [MONTH_W-1:0] month_n;
  logic [YEAR_W-1:0]  year_n;
  logic               roll_n;

  assign fields_ok = (set_sec <= MAX_SEC) && (set_min <= MAX_MIN) && (set_hour <= MAX_HOUR) &&
                     (set_month != '0) && (set_month <= MAX_MONTH) && (set_year <= YMAX) &&
                     (set_day != '0) && (set_day <= days_in_month(set_month, set_year));

  // Handshake: the requester holds set_valid and the fields stable; set_ready is high for
  // exactly one cycle (RESP) and the transfer completes on the edge where valid & ready.
  // Dropping set_valid before RESP abandons the request silently.
  assign set_ready = (state_q == RESP);
  assign set_err   = (state_q == RESP) && err_q;
  assign load      = (state_q == RESP) && set_valid && !err_q;
  assign set_state = state_q;

  rtc_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .clear (load),
    .tick  (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (set_valid) state_d = CHECK;
      CHECK:   state_d = set_valid ? RESP : IDLE;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Range check is registered during CHECK so RESP reports from a flop.
  always_ff @(posedge clk) begin
    if (rst)                   err_q <= 1'b0;
    else if (state_q == CHECK) err_q <= !fields_ok;
  end

  always_comb begin
    sec_n   = second;
    min_n   = minute;
    hour_n  = hour;
    day_n   = day;
    month_n = month;
    year_n  = year;
    roll_n  = 1'b0;
    if (second != MAX_SEC) begin
      sec_n = second + 6'd1;
    end else begin
      sec_n = '0;
      if (minute != MAX_MIN) begin
        min_n = minute + 6'd1;
      end else begin
        min_n = '0;
        if (hour != MAX_HOUR) begin
          hour_n = hour + 5'd1;
        end else begin
          hour_n = '0;
          roll_n = 1'b1;
          if (day != days_in_month(month, year)) begin
            day_n = day + 5'd1;
          end else begin
            day_n = 5'd1;
            if (month != MAX_MONTH) begin
              month_n = month + 4'd1;
            end else begin
              month_n = 4'd1;
              year_n  = (year == YMAX) ? '0 : year + 7'd1;
            end
          end
        end
      end
    end
  end

  // A load in the same cycle as a prescaler wrap replaces the increment entirely.
  always_ff @(posedge clk) begin
    if (rst) begin
      second   <= '0;
      minute   <= '0;
      hour     <= '0;
      day      <= 5'd1;
      month    <= 4'd1;
      year     <= '0;
      tick_1hz <= 1'b0;
      day_roll <= 1'b0;
    end else begin
      tick_1hz <= wrap && !load;
      day_roll <= wrap && !load && roll_n;
      if (load) begin
        second <= set_sec;
        minute <= set_min;
        hour   <= set_hour;
        day    <= set_day;
        month  <= set_month;
        year   <= set_year;
      end else if (wrap) begin
        second <= sec_n;
        minute <= min_n;
        hour   <= hour_n;
        day    <= day_n;
        month  <= month_n;
        year   <= year_n;
      end
    end
  end

endmodule
